// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequential ALU front end. Three push buttons load the A
// operand, the B operand and the opcode from a switch bank. Once all three
// are loaded, the FSM spends one EXEC cycle registering the result. Each
// button is synchronized and edge-detected, so a held button loads only once.
// Optional feature: define ALU_SEQ_ACC_EN to feed each result back into A
// (accumulator chaining); without it, A must be reloaded for every operation.
module alu_seq_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_res,
  output logic               o_carry,
  output logic               o_zero,
  output logic               o_valid,
  output logic               o_busy
);

  typedef enum logic {ST_COLLECT, ST_EXEC} state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  // Shift amounts at or above this saturate instead of wrapping.
  localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA[NB_DATA-1:0];

  // Button vectors are ordered {op, b, a}.
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d, arm_q, arm_d;
  logic [1:0] warm_q, warm_d;
  logic [2:0] btn_edge;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               flag_a_q, flag_a_d, flag_b_q, flag_b_d, flag_op_q, flag_op_d;
  logic               carry_q, carry_d, zero_q, zero_d, valid_q, valid_d;

  logic [NB_DATA-1:0] alu_res;
  logic               alu_carry;

  // Synchronizer, edge detector and post-reset arming. A button is armed only
  // after the synchronizer has filled (warm_q == 2) and the button has been
  // seen released, so a button held through reset cannot fake a press.
  always_comb begin
    // NOTE: every variable written here is assigned on every path, so no latch is inferred.
    sync1_d  = {i_btn_op, i_btn_b, i_btn_a};
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    warm_d   = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    arm_d    = arm_q | ({3{warm_q == 2'd2}} & ~sync2_q);
    btn_edge = sync2_q & ~dly_q & arm_q;
  end

  // Result datapath, driven from the registered operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SRA: begin
        if (b_q >= SHIFT_LIM) alu_res = {NB_DATA{a_q[NB_DATA-1]}};
        else                  alu_res = $signed(a_q) >>> b_q;
      end
      OP_SRL: begin
        if (b_q >= SHIFT_LIM) alu_res = '0;
        else                  alu_res = a_q >> b_q;
      end
      default: alu_res = '0;
    endcase
  end

  // FSM next state, operand loading with A > B > OP priority, result capture.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    flag_a_d  = flag_a_q;
    flag_b_d  = flag_b_q;
    flag_op_d = flag_op_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (btn_edge[0]) begin
          a_d      = i_sw;
          flag_a_d = 1'b1;
        end else if (btn_edge[1]) begin
          b_d      = i_sw;
          flag_b_d = 1'b1;
        end else if (btn_edge[2]) begin
          op_d      = i_sw[NB_OP-1:0];
          flag_op_d = 1'b1;
        end
        if (flag_a_q && flag_b_q && flag_op_q) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d     = alu_res;
        carry_d   = alu_carry;
        zero_d    = (alu_res == '0);
        valid_d   = 1'b1;
        flag_b_d  = 1'b0;
        flag_op_d = 1'b0;
`ifdef ALU_SEQ_ACC_EN
        a_d       = alu_res;
        flag_a_d  = 1'b1;
`else
        flag_a_d  = 1'b0;
`endif
        state_d   = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // State register; o_zero resets high because the cleared result is zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      dly_q     <= '0;
      arm_q     <= '0;
      warm_q    <= '0;
      state_q   <= ST_COLLECT;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      flag_a_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      flag_op_q <= 1'b0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dly_q     <= dly_d;
      arm_q     <= arm_d;
      warm_q    <= warm_d;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      flag_op_q <= flag_op_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
    end
  end

  assign o_res   = res_q;
  assign o_carry = carry_q;
  assign o_zero  = zero_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == ST_EXEC);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed-vector bench for alu_seq_ctrl (NB_DATA=8).
// Expected values are hand-computed; the accumulator variant is selected by
// the same ALU_SEQ_ACC_EN macro as the design.
module tb_alu_seq_ctrl;

  localparam int NB_DATA = 8;
  localparam logic [7:0] ADD = 8'h20, SUB = 8'h22, AND_ = 8'h24, OR_ = 8'h25,
                         XOR_ = 8'h26, NOR_ = 8'h27, SRA = 8'h03, SRL = 8'h02;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b0;
  logic [NB_DATA-1:0] i_sw = '0;
  logic               i_btn_a = 1'b0, i_btn_b = 1'b0, i_btn_op = 1'b0;
  logic [NB_DATA-1:0] o_res;
  logic               o_carry, o_zero, o_valid, o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;

  alu_seq_ctrl #(.NB_DATA(NB_DATA), .NB_OP(6)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_btn_a (i_btn_a),
    .i_btn_b (i_btn_b),
    .i_btn_op(i_btn_op),
    .o_res   (o_res),
    .o_carry (o_carry),
    .o_zero  (o_zero),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Count result pulses, sampled on the inactive edge.
  always @(negedge i_clk) if (o_valid) vcnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // which: 0 = A, 1 = B, 2 = OP
  task automatic press(input int which, input logic [7:0] val);
    @(negedge i_clk);
    i_sw = val;
    case (which)
      0:       i_btn_a  = 1'b1;
      1:       i_btn_b  = 1'b1;
      default: i_btn_op = 1'b1;
    endcase
    repeat (4) @(negedge i_clk);
    i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_result(input string tag, input int v0, input int exp_pulses,
                              input logic [7:0] er, input logic ec, input logic ez);
    repeat (3) @(negedge i_clk);
    check({tag, "_pulses"}, vcnt - v0, exp_pulses);
    check({tag, "_res"}, o_res, er);
    check({tag, "_carry"}, o_carry, ec);
    check({tag, "_zero"}, o_zero, ez);
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [7:0] er, input logic ec,
                       input logic ez);
    int v0;
    v0 = vcnt;
    press(0, a);
    press(1, b);
    press(2, op);
    check_result(tag, v0, 1, er, ec, ez);
  endtask

  initial begin
    int v0;
    int seen;

    // Reset state.
    repeat (3) @(negedge i_clk);
    check("rst_res", o_res, 8'h00);
    check("rst_carry", o_carry, 1'b0);
    check("rst_zero", o_zero, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    i_reset = 1'b1;
    repeat (5) @(negedge i_clk);

    // Opcode coverage and arithmetic boundaries.
    do_op("add_basic", 8'h0F, 8'h01, ADD, 8'h10, 1'b0, 1'b0);
    do_op("add_wrap",  8'hFF, 8'h01, ADD, 8'h00, 1'b1, 1'b1);
    do_op("sub_borrow", 8'h01, 8'h02, SUB, 8'hFF, 1'b1, 1'b0);
    do_op("sra_big",   8'h80, 8'h09, SRA, 8'hFF, 1'b0, 1'b0);
    do_op("srl_big",   8'h80, 8'h09, SRL, 8'h00, 1'b0, 1'b1);
    do_op("undef_op",  8'h80, 8'h09, 8'h3F, 8'h00, 1'b0, 1'b1);
    do_op("sra_3",     8'h80, 8'h03, SRA, 8'hF0, 1'b0, 1'b0);
    do_op("srl_3",     8'h80, 8'h03, SRL, 8'h10, 1'b0, 1'b0);
    do_op("and",       8'hCA, 8'h5C, AND_, 8'h48, 1'b0, 1'b0);
    do_op("or",        8'hCA, 8'h5C, OR_, 8'hDE, 1'b0, 1'b0);
    do_op("xor",       8'hCA, 8'h5C, XOR_, 8'h96, 1'b0, 1'b0);
    do_op("nor",       8'hCA, 8'h5C, NOR_, 8'h21, 1'b0, 1'b0);
    do_op("sub_plain", 8'h10, 8'h03, SUB, 8'h0D, 1'b0, 1'b0);

    // Held A button: switch changes mid-hold, only the first value loads.
    v0 = vcnt;
    @(negedge i_clk);
    i_sw = 8'h11;
    i_btn_a = 1'b1;
    repeat (10) @(negedge i_clk);
    i_sw = 8'h22;
    repeat (10) @(negedge i_clk);
    i_btn_a = 1'b0;
    repeat (3) @(negedge i_clk);
    press(1, 8'h01);
    press(2, ADD);
    check_result("hold_a", v0, 1, 8'h12, 1'b0, 1'b0);

    // A and B edges in the same cycle: only A loads, so OP alone cannot start EXEC.
    v0 = vcnt;
    @(negedge i_clk);
    i_sw = 8'h33;
    i_btn_a = 1'b1;
    i_btn_b = 1'b1;
    repeat (4) @(negedge i_clk);
    i_btn_a = 1'b0; i_btn_b = 1'b0;
    repeat (3) @(negedge i_clk);
    press(2, ADD);
    repeat (3) @(negedge i_clk);
    check("simul_no_exec", vcnt - v0, 0);
    press(1, 8'h01);
    check_result("simul_then_b", v0, 1, 8'h34, 1'b0, 1'b0);

    // Chaining: second operation supplies only B and OP.
    do_op("chain_first", 8'h05, 8'h03, ADD, 8'h08, 1'b0, 1'b0);
    v0 = vcnt;
    press(1, 8'h02);
    press(2, SUB);
`ifdef ALU_SEQ_ACC_EN
    check_result("chain_acc", v0, 1, 8'h06, 1'b0, 1'b0);
`else
    check_result("chain_noacc", v0, 0, 8'h08, 1'b0, 1'b0);
    press(0, 8'h07);
    check_result("chain_reload_a", v0, 1, 8'h05, 1'b0, 1'b0);
`endif

    // Reset asserted during EXEC aborts the operation asynchronously.
    v0 = vcnt;
    press(0, 8'h21);
    press(1, 8'h01);
    @(negedge i_clk);
    i_sw = ADD;
    i_btn_op = 1'b1;
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      @(negedge i_clk);
      if (o_busy) seen = 1;
    end
    check("exec_reached", seen, 1);
    #1 i_reset = 1'b0;
    #1;
    check("mid_rst_res", o_res, 8'h00);
    check("mid_rst_carry", o_carry, 1'b0);
    check("mid_rst_zero", o_zero, 1'b1);
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    i_btn_op = 1'b0;
    repeat (4) @(negedge i_clk);
    check("mid_rst_no_pulse", vcnt - v0, 0);

    // Button A held through reset release must not load until re-pressed.
    @(negedge i_clk);
    i_sw = 8'h44;
    i_btn_a = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (10) @(negedge i_clk);
    i_btn_a = 1'b0;
    repeat (3) @(negedge i_clk);
    v0 = vcnt;
    press(1, 8'h01);
    press(2, ADD);
    repeat (3) @(negedge i_clk);
    check("held_rst_no_load", vcnt - v0, 0);
    press(0, 8'h50);
    check_result("held_rst_repress", v0, 1, 8'h51, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result width; SHALL be >= NB_OP.
REQ-002 Parameter NB_OP, default 6, opcode width, taken from i_sw[NB_OP-1:0].
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_sw  in  NB_DATA  switch value to load.
REQ-006 i_btn_a / i_btn_b / i_btn_op  in  1 each  raw asynchronous buttons: load A, B, opcode.
REQ-007 o_res  out  NB_DATA  registered result.
REQ-008 o_carry  out  1  registered carry/borrow.
REQ-009 o_zero  out  1  registered, high when result is all zeros.
REQ-010 o_valid  out  1  one-cycle pulse: new result on o_res/o_carry/o_zero.
REQ-011 o_busy  out  1  high while FSM is in EXEC.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a rising-edge detector (sync & ~sync_d); load acts on the detected-edge cycle only, so a held button loads once.
REQ-013 In COLLECT, edge on A SHALL load A <= i_sw and set flag_a; B likewise into B/flag_b; OP loads i_sw[NB_OP-1:0] and sets flag_op.
REQ-014 Simultaneous edges: priority A > B > OP; lower-priority edges in that cycle SHALL be dropped.
REQ-015 Reloading an already-set operand SHALL overwrite it; the flag stays set.
REQ-016 FSM states: COLLECT (reset state), EXEC.
REQ-017 COLLECT -> EXEC on the first clock where flag_a & flag_b & flag_op are all set; EXEC -> COLLECT unconditionally after one cycle.
REQ-018 In EXEC, result/carry/zero SHALL be registered from A, B, opcode; o_valid SHALL be high in the next cycle only.
REQ-019 Button edges detected while in EXEC SHALL be ignored.
REQ-020 Leaving EXEC SHALL clear flag_b and flag_op; flag_a per REQ-030/031.
REQ-021 Opcodes: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
REQ-022 ADD: carry = bit NB_DATA of the (NB_DATA+1)-bit unsigned sum.
REQ-023 SUB: res = A-B mod 2^NB_DATA; carry = 1 when A < B unsigned (borrow).
REQ-024 SRA/SRL: A shifted right by B (unsigned); B >= NB_DATA SHALL yield all-zero (SRL) or all-sign-bit (SRA); carry 0.
REQ-025 Logic ops and undefined opcodes: carry 0; undefined opcodes SHALL yield res 0.
REQ-026 o_zero SHALL be computed from the registered result width only, not the carry.
REQ-027 o_res/o_carry/o_zero SHALL hold their value until the next EXEC.

Reset
REQ-028 While i_reset is low: state COLLECT; A, B, opcode, all flags, synchronizer/edge flops, o_res, o_carry, o_valid, o_busy SHALL be 0; o_zero SHALL be 1.
REQ-029 Reset asserted mid-EXEC SHALL abort with no o_valid pulse; a button held across deassertion SHALL not produce an edge before it is released and re-pressed.

Configuration
REQ-030 Macro ALU_SEQ_ACC_EN defined: leaving EXEC SHALL load A <= new result and keep flag_a set (accumulator chaining; next operation needs only B and OP).
REQ-031 Macro ALU_SEQ_ACC_EN undefined: leaving EXEC SHALL clear flag_a; A retains value but must be reloaded for the next operation.

Verification
REQ-032 NB_DATA=8: press A with sw=0x0F, B with 0x01, OP with 0x20 -> o_valid pulse, o_res=0x10, o_carry=0, o_zero=0.
REQ-033 A=0xFF, B=0x01, ADD -> o_res=0x00, o_carry=1, o_zero=1; SUB with A=0x01, B=0x02 -> o_res=0xFF, o_carry=1.
REQ-034 A=0x80, B=0x09: SRA -> o_res=0xFF; SRL -> o_res=0x00; undefined opcode 0x3F -> o_res=0x00, o_carry=0.
REQ-035 Button A held 20 cycles with sw changing 0x11->0x22 mid-hold -> A=0x11 only; A and B edges same cycle -> only A loaded, flag_b clear, no EXEC.
REQ-036 With ALU_SEQ_ACC_EN: A=0x05, B=0x03, ADD -> 0x08; then B=0x02, OP=SUB only -> o_res=0x06; without the macro the same second sequence -> no o_valid.
REQ-037 Assert i_reset during EXEC -> no o_valid, all outputs at REQ-028 values immediately (asynchronously).
